// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by shift-add (LSB first) and divides by restoring division
// (MSB first), one bit per cycle, with a final sign-fix cycle.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_LENGTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_LENGTH-1:0]  Op,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [OP_LENGTH-1:0]  r_op;
   logic [W-1:0]          r_a_mag;
   logic [W-1:0]          r_b_mag;
   logic                  r_neg_res;
   logic                  r_neg_rem;
   logic                  r_dz;
   logic [CW-1:0]         r_cnt;
   logic [2*W-1:0]        r_acc;
   logic [W:0]            r_rem;
   logic [W-1:0]          r_quo;
   logic [W-1:0]          r_result;

   logic                  w_sign_a_en;
   logic                  w_sign_b_en;
   logic                  w_sign_a;
   logic                  w_sign_b;
   logic [W-1:0]          w_a_mag;
   logic [W-1:0]          w_b_mag;
   logic [W:0]            w_mul_sum;
   logic [W+1:0]          w_div_shift;
   logic                  w_div_ge;
   logic [2*W-1:0]        w_prod;
   logic [W-1:0]          w_quo;
   logic [W-1:0]          w_rem;
   logic [W-1:0]          w_result;

   assign Result = r_result;

   // Operand signedness and magnitudes for the request being offered
   always_comb begin
      w_sign_a_en = 1'b0;
      w_sign_b_en = 1'b0;
      if (Op[2]) begin
         w_sign_a_en = ~Op[0];
         w_sign_b_en = ~Op[0];
      end else begin
         w_sign_a_en = (Op[1:0] == 2'b01) || (Op[1:0] == 2'b10);
         w_sign_b_en = (Op[1:0] == 2'b01);
      end
      w_sign_a = SrcA[W-1] & w_sign_a_en;
      w_sign_b = SrcB[W-1] & w_sign_b_en;
      w_a_mag  = w_sign_a ? -SrcA : SrcA;
      w_b_mag  = w_sign_b ? -SrcB : SrcB;
   end

   // One iteration step of the multiply and divide datapaths
   always_comb begin
      w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
      w_div_shift = {r_rem, r_quo[W-1]};
      w_div_ge    = (w_div_shift >= {2'b00, r_b_mag});
   end

   // Sign fix and result selection, evaluated during FIX
   always_comb begin
      w_prod = r_neg_res ? -r_acc : r_acc;
      w_quo  = r_dz ? '1 : (r_neg_res ? -r_quo : r_quo);
      w_rem  = r_neg_rem ? -r_rem[W-1:0] : r_rem[W-1:0];
      w_result = '0;
      case (r_op)
         3'b000:                   w_result = w_prod[W-1:0];
         3'b001, 3'b010, 3'b011:   w_result = w_prod[2*W-1:W];
         3'b100, 3'b101:           w_result = w_quo;
         default:                  w_result = w_rem;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = S_CALC;
         S_CALC: if (r_cnt == CW'(W-1)) w_next = S_FIX;
         S_FIX:  w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy = (r_state == S_CALC) || (r_state == S_FIX);
      done = (r_state == S_DONE);
   end

   // Datapath registers: latch on accept, iterate in CALC, publish in FIX
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= '0;
         r_a_mag   <= '0;
         r_b_mag   <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op      <= Op;
                  r_a_mag   <= w_a_mag;
                  r_b_mag   <= w_b_mag;
                  r_neg_res <= w_sign_a ^ w_sign_b;
                  r_neg_rem <= w_sign_a;
                  r_dz      <= (SrcB == '0);
                  r_cnt     <= '0;
                  r_acc     <= {{W{1'b0}}, w_b_mag};
                  r_rem     <= '0;
                  r_quo     <= w_a_mag;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_op[2]) begin
                  r_rem <= w_div_ge ? (W+1)'(w_div_shift - {2'b00, r_b_mag})
                                    : (W+1)'(w_div_shift);
                  r_quo <= {r_quo[W-2:0], w_div_ge};
               end else begin
                  r_acc <= {w_mul_sum, r_acc[W-1:1]};
               end
            end
            S_FIX: r_result <= w_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake
// timing, ignored starts, reset abort and randomized ops vs. a model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  Op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] Result;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit #(.DATA_WIDTH(32), .OP_LENGTH(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .Op     (Op),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint          p;
      longint unsigned up;
      logic [31:0]     r;
      case (op)
         3'd0: begin up = ua * ub; r = up[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin up = ua * ub; r = up[63:32]; end
         3'd4: if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
         3'd5: if (b == 0) r = 32'hFFFF_FFFF; else begin up = ua / ub; r = up[31:0]; end
         3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
         default: if (b == 0) r = a; else begin up = ua % ub; r = up[31:0]; end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   // Issue one request, scramble inputs after acceptance, check timing and result
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit full);
      logic [31:0] exp;
      int cyc;
      int nbusy;
      exp = ref_model(op, a, b);
      @(negedge clk);
      start = 1'b1; Op = op; SrcA = a; SrcB = b;
      @(negedge clk);
      start = 1'b0; Op = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      cyc = 1; nbusy = 0;
      while (!done && cyc < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, cyc, 34);
      check({tag, "_result"}, Result, exp);
      if (full) begin
         check({tag, "_busycyc"}, nbusy, 33);
         check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
         @(negedge clk);
         check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
         check({tag, "_hold"}, Result, exp);
      end
   endtask

   initial begin
      int ndone;
      reset = 1'b1; start = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", Result, 32'd0);
      reset = 1'b0;

      run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
      check("mul_neg_const", Result, 32'hFFFF_FFEB);
      run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      check("mulh_min_const", Result, 32'h4000_0000);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("mulhu_max_const", Result, 32'hFFFF_FFFE);
      run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("mulhsu_max_const", Result, 32'hFFFF_FFFF);
      run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg_const", Result, 32'hFFFF_FFFD);
      run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("rem_neg_const", Result, 32'hFFFF_FFFF);
      run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("divu_const", Result, 32'h7FFF_FFFC);
      run_op("remu", 3'd7, 32'd100, 32'd7, 1'b0);
      check("remu_const", Result, 32'd2);
      run_op("div_zero", 3'd4, 32'd5, 32'd0, 1'b0);
      check("div_zero_const", Result, 32'hFFFF_FFFF);
      run_op("remu_zero", 3'd7, 32'd5, 32'd0, 1'b0);
      check("remu_zero_const", Result, 32'd5);
      run_op("rem_zero_neg", 3'd6, 32'hFFFF_FFF9, 32'd0, 1'b0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check("div_ovf_const", Result, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("rem_ovf_const", Result, 32'd0);

      // Second start mid-operation and a start during DONE are both ignored
      @(negedge clk);
      start = 1'b1; Op = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
      ndone = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) ndone++;
         start = (i == 10) || done;
         if (i == 10) begin Op = 3'd4; SrcA = 32'd100; SrcB = 32'd100; end
         if (done) check("ign_result", Result, 32'd12);
      end
      start = 1'b0;
      check("ign_dones", ndone, 1);
      check("ign_idle", {31'd0, busy}, 32'd0);
      check("ign_result_final", Result, 32'd12);

      // Reset in the middle of a divide aborts it
      @(negedge clk);
      start = 1'b1; Op = 3'd5; SrcA = 32'd1000; SrcB = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", Result, 32'd0);
      ndone = 0;
      repeat (50) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op("after_abort", 3'd5, 32'd1000, 32'd7, 1'b1);
      check("after_abort_const", Result, 32'd142);

      // Randomized requests against the model
      for (int k = 0; k < 60; k++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 3'($urandom_range(0, 7));
         ra  = rand_operand();
         rb  = rand_operand();
         run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, (k % 8) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
